// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad emulator
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BOUNCE_IN  = 3'd1,
        ST_HOLD       = 3'd2,
        ST_BOUNCE_OUT = 3'd3,
        ST_GAP        = 3'd4
    } kp_state_e;

    typedef struct packed {
        logic [1:0] row_idx;
        logic [1:0] col_idx;
    } key_code_t;

    localparam logic [3:0] ROW_IDLE  = 4'b1111;
    localparam logic [7:0] LFSR_SEED = 8'h01;
    // Galois right-shift mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// rtl/bounce_lfsr.sv - 8-bit Galois LFSR supplying pseudo-random contact bounce
module bounce_lfsr
    import keypad_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic q
);

    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (en) begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 8'h00);
        end
    end

    assign q = r_lfsr[0];

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad emulator; optional contact bounce via KEYPAD_EMU_BOUNCE_EN
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 200,
    parameter int BOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       busy,
    output logic       press_done
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    kp_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    key_code_t        key_r;
    logic             r_press_done;
    logic             w_contact;
    logic [3:0]       w_row;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    localparam kp_state_e ST_AFTER_IDLE = ST_BOUNCE_IN;
    localparam kp_state_e ST_AFTER_HOLD = ST_BOUNCE_OUT;

    logic w_bouncing;
    logic w_lfsr_bit;

    assign w_bouncing = (r_state == ST_BOUNCE_IN) || (r_state == ST_BOUNCE_OUT);

    bounce_lfsr u_bounce_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_bouncing),
        .q     (w_lfsr_bit)
    );

    assign w_contact = (r_state == ST_HOLD) || (w_bouncing && w_lfsr_bit);
`else
    localparam kp_state_e ST_AFTER_IDLE = ST_HOLD;
    localparam kp_state_e ST_AFTER_HOLD = ST_GAP;

    assign w_contact = (r_state == ST_HOLD);
`endif

    // Every transition clears the phase counter; press_done marks the first GAP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            key_r        <= '0;
            r_press_done <= 1'b0;
        end else begin
            r_press_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (key_valid) begin
                        key_r   <= key_code;
                        r_cnt   <= '0;
                        r_state <= ST_AFTER_IDLE;
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                ST_BOUNCE_IN: begin
                    if (r_cnt == BOUNCE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
`endif
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt        <= '0;
                        r_state      <= ST_AFTER_HOLD;
                        r_press_done <= (ST_AFTER_HOLD == ST_GAP);
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                ST_BOUNCE_OUT: begin
                    if (r_cnt == BOUNCE_LAST) begin
                        r_cnt        <= '0;
                        r_state      <= ST_GAP;
                        r_press_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
`endif
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pure combinational path from col so the scanner sees the key in the same cycle.
    always_comb begin
        w_row = ROW_IDLE;
        if (w_contact && !col[key_r.col_idx]) begin
            w_row[key_r.row_idx] = 1'b0;
        end
    end

    assign row        = w_row;
    assign key_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign press_done = r_press_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - directed self-checking bench for keypad_emulator
module tb_keypad_emulator;

    localparam int HOLD   = 8;
    localparam int GAP    = 4;
    localparam int BOUNCE = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'b0000;
    logic       key_ready;
    logic [3:0] col = 4'b0000;
    logic [3:0] row;
    logic       busy;
    logic       press_done;

    int checks = 0;
    int failures = 0;

    keypad_emulator #(
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .BOUNCE_CYCLES (BOUNCE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .col        (col),
        .row        (row),
        .busy       (busy),
        .press_done (press_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (key_ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {3'b000, key_ready}, 4'b0001);
    endtask

    initial begin
        // Reset state with every column driven low
        col = 4'b0000;
        #2;
        chk("rst_row", row, 4'b1111);
        chk("rst_ready", {3'b000, key_ready}, 4'b0001);
        chk("rst_busy", {3'b000, busy}, 4'b0000);
        chk("rst_pd", {3'b000, press_done}, 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic press of key 0 (row 0, col 0)
        col = 4'b1110;
        key_code = 4'b0000;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            chk("press_row", row, (i <= HOLD) ? 4'b1110 : 4'b1111);
            chk("press_pd", {3'b000, press_done}, (i == HOLD + 1) ? 4'b0001 : 4'b0000);
            chk("press_ready", {3'b000, key_ready}, (i >= HOLD + GAP + 1) ? 4'b0001 : 4'b0000);
            tick();
        end

        // Row 3 / col 0 with the scanner alternating between col 0 and col 1
        key_code = 4'b1100;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 1; i <= HOLD; i++) begin
            col = 4'b1110;
            #1;
            chk("colsel_hit", row, 4'b0111);
            col = 4'b1101;
            #1;
            chk("colsel_miss", row, 4'b1111);
            tick();
        end
        wait_idle("colsel_idle");

        // key_valid held, code changed mid-press: next accept exactly when ready
        col = 4'b1001;
        key_code = 4'b0101;
        key_valid = 1'b1;
        tick();
        key_code = 4'b1010;
        for (int i = 1; i <= 14; i++) begin
            chk("b2b_row", row, (i <= HOLD) ? 4'b1101 : ((i == 14) ? 4'b1011 : 4'b1111));
            chk("b2b_ready", {3'b000, key_ready}, (i == 13) ? 4'b0001 : 4'b0000);
            tick();
        end
        key_valid = 1'b0;
        wait_idle("b2b_idle");

        // Asynchronous reset in the middle of HOLD
        col = 4'b1110;
        key_code = 4'b0000;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
        tick();
        chk("midrst_pre_row", row, 4'b1110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_row", row, 4'b1111);
        chk("midrst_ready", {3'b000, key_ready}, 4'b0001);
        chk("midrst_busy", {3'b000, busy}, 4'b0000);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("midrst_pd", {3'b000, press_done}, 4'b0000);
            chk("midrst_idle", {2'b00, key_ready, busy}, 4'b0010);
            chk("midrst_row_after", row, 4'b1111);
        end

`ifdef KEYPAD_EMU_BOUNCE_EN
        begin
            int         trans_in;
            int         trans_out;
            logic [3:0] prev;
            trans_in = 0;
            trans_out = 0;
            prev = 4'b1111;
            col = 4'b1110;
            key_code = 4'b0000;
            key_valid = 1'b1;
            tick();
            key_valid = 1'b0;
            for (int i = 1; i <= 2 * BOUNCE + HOLD + GAP + 1; i++) begin
                if (i <= BOUNCE && row !== prev) trans_in++;
                if (i > BOUNCE + HOLD && i <= 2 * BOUNCE + HOLD && row !== prev) trans_out++;
                if (i > BOUNCE && i <= BOUNCE + HOLD) chk("bnc_hold_row", row, 4'b1110);
                chk("bnc_ready", {3'b000, key_ready},
                    (i == 2 * BOUNCE + HOLD + GAP + 1) ? 4'b0001 : 4'b0000);
                prev = row;
                tick();
            end
            chk("bnc_in_toggles", {3'b000, trans_in >= 2}, 4'b0001);
            chk("bnc_out_toggles", {3'b000, trans_out >= 2}, 4'b0001);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable model of a 4x4 matrix keypad: it drives the row lines a column-scanning keypad reader samples. Upstream logic issues a key code through a valid/ready handshake. The block then "presses" that key for a programmed hold time and releases it, pulling the matching row low whenever the scanner drives that key's column low. Used in the FYP system to inject keypresses from internal logic or test stimulus without a physical keypad.

## Interface
- `HOLD_CYCLES`, default 1000: cycles the contact stays closed; must be ≥1.
- `GAP_CYCLES`, default 200: released cycles after a press before the next code is accepted; must be ≥1.
- `BOUNCE_CYCLES`, default 16: bounce window length at press and at release; used only with the bounce macro; must be ≥1.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `key_valid`  in  1  upstream has a key code to press.
- `key_code`  in  4  bits [3:2] are the row index, bits [1:0] are the column index.
- `key_ready`  out  1  block is idle and accepts a code.
- `col`  in  4  column drive from the scanner; active-low.
- `row`  out  4  row lines to the scanner; active-low; idle value is 4'b1111.
- `busy`  out  1  a press/release sequence is in progress.
- `press_done`  out  1  one-cycle pulse when the hold phase ends.

## Operation
- FSM states:
  - IDLE
  - BOUNCE_IN (macro only)
  - HOLD
  - BOUNCE_OUT (macro only)
  - GAP
- Accepting a code:
  - `key_ready` = (state == IDLE).
  - `busy` = !`key_ready`.
  - A code is accepted when `key_valid` && `key_ready` at a rising edge. `key_code` is latched into `key_r`.
- Transitions:
  - IDLE → BOUNCE_IN (macro) or HOLD on accept.
  - BOUNCE_IN → HOLD after BOUNCE_CYCLES.
  - HOLD → BOUNCE_OUT (macro) or GAP after HOLD_CYCLES.
  - BOUNCE_OUT → GAP after BOUNCE_CYCLES.
  - GAP → IDLE after GAP_CYCLES.
- Contact signal (`contact`):
  - 1 in HOLD.
  - Pseudo-random in BOUNCE states.
  - 0 in IDLE and GAP.
- Row output is combinational from registered state plus `col`:
  - `row[r]` = 0 iff `contact` && `key_r[3:2]` == r && `col[key_r[1:0]]` == 0.
  - Otherwise `row[r]` = 1.
  - At most one row bit is ever low.
- Inputs outside IDLE:
  - `key_valid` outside IDLE is ignored; there is no queue.
  - `key_code` changes after acceptance have no effect.
- Phase counter:
  - Width is $clog2(max(HOLD, GAP, BOUNCE)) + 1.
  - Cleared on every state entry.
  - Counts 0..N-1; the state is left on count N-1.
- `press_done` pulses high for exactly the first GAP cycle.
- Reset, asserted at any time including mid-press:
  - state = IDLE and counter = 0.
  - `row` = 4'b1111 immediately, independent of `col`.
  - `busy` = 0, `press_done` = 0, `key_ready` = 1.
  - `key_r` = 0.
  - LFSR = 8'h01.

## Timing
- Accept at edge T, bounce macro off:
  - `row` responds to `col` during cycles T+1 .. T+HOLD.
  - `press_done` is high in cycle T+HOLD+1.
  - `key_ready` rises at T+HOLD+GAP+1.
- Bounce macro on:
  - Hold starts at T+BOUNCE+1.
  - `key_ready` returns at T+2·BOUNCE+HOLD+GAP+1.
- Back-to-back presses: with `key_valid` held high, the next accept is on the first edge where `key_ready` = 1. That is a period of HOLD+GAP+1 cycles, or HOLD+GAP+2·BOUNCE+1 with the macro.
- `row` has zero-cycle latency from `col` (pure combinational path). A `col` change in the same cycle is reflected in that cycle's `row`.

## Configuration
- `KEYPAD_EMU_BOUNCE_EN` defined:
  - BOUNCE_IN and BOUNCE_OUT exist.
  - `contact` = LFSR bit 0 during those states.
  - The LFSR advances every cycle in a bounce state.
- `KEYPAD_EMU_BOUNCE_EN` undefined:
  - Bounce states, the LFSR and BOUNCE_CYCLES logic are absent.
  - Contact is clean: 0 → 1 at hold start, 1 → 0 at hold end.

## Structure
- Package `keypad_pkg` holds:
  - `kp_state_e` (state enum).
  - `key_code_t` (4-bit packed struct: `row_idx[1:0]`, `col_idx[1:0]`).
  - Constant `ROW_IDLE` = 4'b1111.
- One sub-module, `bounce_lfsr`:
  - 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'h01.
  - Ports: `clk`, `rst_n`, `en`, `q`.
  - Instantiated only under the macro.

## Test plan
- Reset: `rst_n` = 0 with `col` = 4'b0000 → `row` = 4'b1111, `key_ready` = 1, `busy` = 0, `press_done` = 0.
- Press code 4'b0000, HOLD = 8, GAP = 4, `col` = 4'b1110 → `row` = 4'b1110 for exactly 8 cycles. `press_done` pulses once at T+9. `key_ready` returns at T+13.
- Column mismatch: press code 4'b1100 with `col` toggling between 4'b1110 and 4'b1101:
  - `row` = 4'b0111 only while `col` = 4'b1110.
  - `row` = 4'b1111 while `col` = 4'b1101.
- `key_valid` held high with code changed mid-press: the new code is ignored until `key_ready`, then accepted on that exact edge. The inter-accept period is 13 cycles.
- Reset pulse in the middle of HOLD → `row` = 4'b1111 asynchronously. After release, `key_ready` = 1 and no `press_done` is produced.
- Macro on, BOUNCE = 16:
  - ≥2 `row` transitions occur within each bounce window.
  - `row` is stable low across all HOLD cycles.
  - `key_ready` returns at T+2·16+HOLD+GAP+1.
